// File: rtl/data_mem_lsu.sv
// Byte-addressable load/store unit over a DEPTH x 32 word memory with RV32I sizes and fault capture.
// Latency: a load returns RD/rvalid, and any access returns fault, one cycle after the accepting edge.
// Backpressure: none; a request is accepted every cycle that req is high.
module data_mem_lsu #(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] A,
  input  logic [31:0]   WD,
  input  logic          err_clr,
  output logic [31:0]   RD,
  output logic          rvalid,
  output logic          fault,
  output logic          err,
  output logic [AW-1:0] err_addr
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [AW-2:0] DEPTH_W = (AW-1)'(DEPTH);

  logic [31:0] mem [DEPTH];

  logic          bad_f3;
  logic          misalign;
  logic          oor;
  logic          acc_flt;
  logic [IW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wlane;

  logic          p_ld;
  logic          p_flt;
  logic [2:0]    p_f3;
  logic [AW-1:0] p_addr;

  assign widx = A[IW+1:2];

  always_comb begin
    bad_f3   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    misalign = ((funct3[1:0] == 2'b01) && A[0]) ||
               ((funct3[1:0] == 2'b10) && (A[1:0] != 2'b00));
    oor      = {1'b0, A[AW-1:2]} >= DEPTH_W;
    acc_flt  = bad_f3 || misalign || oor;
  end

  // Sub-word store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b1111;
    wlane = WD;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << A[1:0];
        wlane = {4{WD[7:0]}};
      end
      2'b01: begin
        be    = A[1] ? 4'b1100 : 4'b0011;
        wlane = {2{WD[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = WD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && req && we && !acc_flt) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_ld   <= 1'b0;
      p_flt  <= 1'b0;
      p_f3   <= '0;
      p_addr <= '0;
    end else begin
      p_ld  <= req && !we;
      p_flt <= req && acc_flt;
      if (req) begin
        p_f3   <= funct3;
        p_addr <= A;
      end
    end
  end

  // A fault registering on the same edge as err_clr takes priority and re-captures its address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RD       <= '0;
      rvalid   <= 1'b0;
      fault    <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      rvalid <= p_ld;
      fault  <= p_flt;
      if (p_ld) RD <= p_flt ? '0 : load_ext(mem[p_addr[IW+1:2]], p_addr[1:0], p_f3);
      if (p_flt) begin
        err <= 1'b1;
        if (!err || err_clr) err_addr <= p_addr;
      end else if (err_clr) begin
        err      <= 1'b0;
        err_addr <= '0;
      end
    end
  end
endmodule
